rf_write_arbiter: RTL and testbench

//  Shares the register file's single write port (WE3/AD3/WD3) between two requesters.
//  - Requester 1: pipeline writeback (WB stage).
//  - Requester 2: multi-cycle producers (divider, late load return), via valid/ready.
//  WB has priority. Multi-cycle results queue in a small FIFO.
//  A starvation counter forces FIFO drains. Busy flags let the hazard unit stall reads of pending registers.

---
 rtl/rf_arb_pkg.sv | 20 ++
 rtl/rf_wr_fifo.sv | 83 ++++++++
 rtl/rf_write_arbiter.sv | 127 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_arb_pkg;

    localparam int ADDRESS_WIDTH = 5;
    localparam int DATA_WIDTH    = 32;
    localparam logic [ADDRESS_WIDTH-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
    } wr_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_MC,
        GNT_KILL
    } grant_e;

endpackage

// File: rtl/rf_wr_fifo.sv
// Circular write queue for multi-cycle results. Each entry carries a live bit
// that a younger WB write to the same register can clear (kill-by-address),
// plus two address match ports used to flag pending source registers.
module rf_wr_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  wr_req_t                  i_push_req,
    input  logic                     i_pop,
    input  logic                     i_kill,
    input  logic [ADDRESS_WIDTH-1:0] i_kill_addr,
    input  logic [ADDRESS_WIDTH-1:0] i_match0_addr,
    input  logic [ADDRESS_WIDTH-1:0] i_match1_addr,
    output wr_req_t                  o_head,
    output logic                     o_head_live,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_match0,
    output logic                     o_match1
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wr_req_t          r_mem [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] w_live_nxt;

    // Storage for queued writes; contents only matter while counted.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_req;
    end

    // Kill applies to already-registered entries only, so the push is folded in last.
    always_comb begin
        w_live_nxt = r_live;
        if (i_kill) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_mem[i].addr == i_kill_addr) w_live_nxt[i] = 1'b0;
            end
        end
        if (i_pop)  w_live_nxt[r_rd_ptr] = 1'b0;
        if (i_push) w_live_nxt[r_wr_ptr] = 1'b1;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_live   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_live   <= w_live_nxt;
            r_wr_ptr <= r_wr_ptr + PW'(i_push);
            r_rd_ptr <= r_rd_ptr + PW'(i_pop);
            r_count  <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    // Source-register match against live entries; x0 is never pending.
    always_comb begin
        o_match0 = 1'b0;
        o_match1 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i] && r_mem[i].addr == i_match0_addr) o_match0 = 1'b1;
            if (r_live[i] && r_mem[i].addr == i_match1_addr) o_match1 = 1'b1;
        end
        if (i_match0_addr == REG_ZERO) o_match0 = 1'b0;
        if (i_match1_addr == REG_ZERO) o_match1 = 1'b0;
    end

    assign o_head      = r_mem[r_rd_ptr];
    assign o_head_live = r_live[r_rd_ptr];
    assign o_count     = r_count;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register file's single write port between pipeline
// writeback (priority) and a queue of multi-cycle results, with a starvation
// counter that forces the queue head through after repeated losses.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wb_we,
    input  logic [ADDRESS_WIDTH-1:0] i_wb_addr,
    input  logic [DATA_WIDTH-1:0]    i_wb_data,
    output logic                     o_wb_stall,
    input  logic                     i_mc_valid,
    output logic                     o_mc_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_mc_addr,
    input  logic [DATA_WIDTH-1:0]    i_mc_data,
    input  logic [ADDRESS_WIDTH-1:0] i_rs1_addr,
    input  logic [ADDRESS_WIDTH-1:0] i_rs2_addr,
    output logic                     o_rs1_busy,
    output logic                     o_rs2_busy,
    output logic                     o_rf_we3,
    output logic [ADDRESS_WIDTH-1:0] o_rf_ad3,
    output logic [DATA_WIDTH-1:0]    o_rf_wd3,
    output logic                     o_pending
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] r_starve;
    grant_e        w_grant;
    wr_req_t       w_head;
    wr_req_t       w_push_req;
    logic          w_head_live;
    logic [CW-1:0] w_count;
    logic          w_fifo_ne;
    logic          w_wb_req;
    logic          w_mc_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_kill;
    logic          w_match1;
    logic          w_match2;

    assign w_fifo_ne  = (w_count != '0);
    assign w_wb_req   = i_wb_we && (i_wb_addr != REG_ZERO);
    assign w_mc_ready = i_rst_n && (w_count < CW'(FIFO_DEPTH));
    // x0 results complete the handshake but are dropped instead of queued.
    assign w_push     = i_mc_valid && w_mc_ready && (i_mc_addr != REG_ZERO);
    assign w_push_req = '{addr: i_mc_addr, data: i_mc_data};
    assign w_pop      = (w_grant == GNT_MC) || (w_grant == GNT_KILL);
    assign w_kill     = (w_grant == GNT_WB);

    rf_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_push        (w_push),
        .i_push_req    (w_push_req),
        .i_pop         (w_pop),
        .i_kill        (w_kill),
        .i_kill_addr   (i_wb_addr),
        .i_match0_addr (i_rs1_addr),
        .i_match1_addr (i_rs2_addr),
        .o_head        (w_head),
        .o_head_live   (w_head_live),
        .o_count       (w_count),
        .o_match0      (w_match1),
        .o_match1      (w_match2)
    );

    // Priority: starved head, then WB, then head; a killed head still consumes the port.
    always_comb begin
        w_grant = GNT_NONE;
        if (i_rst_n) begin
            if (w_fifo_ne && r_starve == SW'(STARVE_LIMIT)) begin
                w_grant = w_head_live ? GNT_MC : GNT_KILL;
            end else if (w_wb_req) begin
                w_grant = GNT_WB;
            end else if (w_fifo_ne) begin
                w_grant = w_head_live ? GNT_MC : GNT_KILL;
            end
        end
    end

    // Drive the write port from the winner; idle and killed slots write nothing.
    always_comb begin
        o_rf_we3 = 1'b0;
        o_rf_ad3 = '0;
        o_rf_wd3 = '0;
        case (w_grant)
            GNT_WB: begin
                o_rf_we3 = 1'b1;
                o_rf_ad3 = i_wb_addr;
                o_rf_wd3 = i_wb_data;
            end
            GNT_MC: begin
                o_rf_we3 = 1'b1;
                o_rf_ad3 = w_head.addr;
                o_rf_wd3 = w_head.data;
            end
            default: ;
        endcase
    end

    // Count consecutive head losses to WB; cleared whenever the head moves or the queue empties.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve <= '0;
        end else if (!w_fifo_ne || w_pop) begin
            r_starve <= '0;
        end else if (w_grant == GNT_WB && r_starve != SW'(STARVE_LIMIT)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    assign o_wb_stall = i_rst_n && w_wb_req && (w_grant != GNT_WB);
    assign o_mc_ready = w_mc_ready;
    assign o_rs1_busy = i_rst_n && w_match1;
    assign o_rs2_busy = i_rst_n && w_match2;
    assign o_pending  = i_rst_n && w_fifo_ne;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench: a queue-based model predicts each cycle's port activity,
// a negedge monitor pops and compares against the arbiter outputs.
module tb_rf_write_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        wb_stall;
    logic        mc_valid = 1'b0;
    logic        mc_ready;
    logic [4:0]  mc_addr = '0;
    logic [31:0] mc_data = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_we3;
    logic [4:0]  rf_ad3;
    logic [31:0] rf_wd3;
    logic        pending;

    rf_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wb_we    (wb_we),
        .i_wb_addr  (wb_addr),
        .i_wb_data  (wb_data),
        .o_wb_stall (wb_stall),
        .i_mc_valid (mc_valid),
        .o_mc_ready (mc_ready),
        .i_mc_addr  (mc_addr),
        .i_mc_data  (mc_data),
        .i_rs1_addr (rs1_addr),
        .i_rs2_addr (rs2_addr),
        .o_rs1_busy (rs1_busy),
        .o_rs2_busy (rs2_busy),
        .o_rf_we3   (rf_we3),
        .o_rf_ad3   (rf_ad3),
        .o_rf_wd3   (rf_wd3),
        .o_pending  (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  ad;
        logic [31:0] wd;
        bit          chk_adwd;
        logic        stall;
        logic        ready;
        logic        b1;
        logic        b2;
        logic        pend;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          live;
    } ent_t;

    exp_t sb[$];
    ent_t mq[$];
    int   starve = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;

    // Model one cycle: predict outputs from the queue state, then apply the clock-edge effects.
    task automatic step(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md,
                        input logic [4:0] r1, input logic [4:0] r2, output bit acc);
        exp_t e;
        bit ne, wbreq, head_g, wb_g, popped;
        @(posedge clk);
        #1;
        rst_n = rst; wb_we = we; wb_addr = wa; wb_data = wd;
        mc_valid = mv; mc_addr = ma; mc_data = md; rs1_addr = r1; rs2_addr = r2;
        cyc++;
        e.cyc = cyc; e.we = 0; e.ad = 0; e.wd = 0; e.chk_adwd = 1;
        e.stall = 0; e.ready = 0; e.b1 = 0; e.b2 = 0; e.pend = 0;
        acc = 0;
        if (!rst) begin
            mq.delete();
            starve = 0;
            sb.push_back(e);
            return;
        end
        ne = (mq.size() > 0);
        wbreq = we && (wa != 0);
        head_g = 0; wb_g = 0;
        if (ne && starve == LIMIT) head_g = 1;
        else if (wbreq) wb_g = 1;
        else if (ne) head_g = 1;
        e.stall = wbreq && !wb_g;
        if (wb_g) begin
            e.we = 1; e.ad = wa; e.wd = wd;
        end else if (head_g) begin
            if (mq[0].live) begin
                e.we = 1; e.ad = mq[0].a; e.wd = mq[0].d;
            end else begin
                e.chk_adwd = 0;
            end
        end
        e.ready = (mq.size() < DEPTH);
        e.pend = ne;
        foreach (mq[i]) begin
            if (mq[i].live && r1 != 0 && mq[i].a == r1) e.b1 = 1;
            if (mq[i].live && r2 != 0 && mq[i].a == r2) e.b2 = 1;
        end
        sb.push_back(e);
        acc = mv && e.ready;
        popped = head_g;
        if (head_g) void'(mq.pop_front());
        if (wb_g) foreach (mq[i]) if (mq[i].a == wa) mq[i].live = 0;
        if (acc && ma != 0) mq.push_back('{a: ma, d: md, live: 1'b1});
        if (!ne || popped) starve = 0;
        else if (wb_g && starve < LIMIT) starve++;
    endtask

    // Monitor: compare every presented cycle against the oldest prediction.
    initial begin
        exp_t e;
        bit bad;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_vec++;
                bad = (rf_we3 !== e.we) || (wb_stall !== e.stall) || (mc_ready !== e.ready) ||
                      (rs1_busy !== e.b1) || (rs2_busy !== e.b2) || (pending !== e.pend) ||
                      (e.chk_adwd && ((rf_ad3 !== e.ad) || (rf_wd3 !== e.wd)));
                if (bad) begin
                    n_bad++;
                    $display("FAIL port_cyc%0d got we=%b ad=%0d wd=%h stall=%b rdy=%b b1=%b b2=%b pend=%b exp we=%b ad=%0d wd=%h stall=%b rdy=%b b1=%b b2=%b pend=%b",
                             e.cyc, rf_we3, rf_ad3, rf_wd3, wb_stall, mc_ready, rs1_busy, rs2_busy, pending,
                             e.we, e.ad, e.wd, e.stall, e.ready, e.b1, e.b2, e.pend);
                end
            end
        end
    end

    initial begin
        bit acc;
        logic        hv;
        logic [4:0]  ha;
        logic [31:0] hd;
        logic        w;
        logic [4:0]  wa;
        logic [31:0] wd;
        hv = 0; ha = 0; hd = 0;

        // Power-on reset, then release.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        step(0, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2, 5'd4, 0, acc);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, acc);

        // Idle WB, single multi-cycle write x5.
        step(1, 0, 0, 0, 1, 5'd5, 32'hDEAD, 0, 0, acc);
        step(1, 0, 0, 0, 0, 0, 0, 5'd5, 0, acc);
        step(1, 0, 0, 0, 0, 0, 0, 5'd5, 0, acc);

        // Queue x7, then WB x3 every cycle: starvation forces x7 through.
        step(1, 0, 0, 0, 1, 5'd7, 32'h11, 0, 0, acc);
        for (int i = 0; i < 7; i++) step(1, 1, 5'd3, 32'h300 + i, 0, 0, 0, 5'd7, 5'd3, acc);

        // WAW kill of queued x9 by younger WB.
        step(1, 1, 5'd1, 32'h1, 1, 5'd9, 32'hA, 0, 0, acc);
        step(1, 1, 5'd9, 32'hB, 0, 0, 0, 5'd9, 0, acc);
        step(1, 0, 0, 0, 0, 0, 0, 5'd9, 0, acc);
        step(1, 0, 0, 0, 0, 0, 0, 5'd9, 0, acc);

        // Fill the queue while WB holds the port; held mc_valid waits for a pop.
        for (int i = 0; i < 10; i++) step(1, 1, 5'd4, 32'h40 + i, 1, 5'd12, 32'hC0 + i, 5'd12, 5'd4, acc);

        // x0 traffic never writes and is never busy.
        for (int i = 0; i < 4; i++) step(1, 1, 5'd0, 32'hF, 1, 5'd0, 32'hE, 5'd0, 5'd0, acc);

        // Mid-stream reset with two entries queued behind WB.
        step(1, 1, 5'd6, 32'h6, 1, 5'd1, 32'h91, 5'd1, 5'd2, acc);
        step(1, 1, 5'd6, 32'h6, 1, 5'd2, 32'h92, 5'd1, 5'd2, acc);
        step(0, 1, 5'd6, 32'h6, 1, 5'd3, 32'h93, 5'd1, 5'd2, acc);
        step(0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, acc);
        step(1, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, acc);

        // Randomised traffic: producer holds its request until accepted, WB re-presents when stalled.
        w = 0; wa = 0; wd = 0;
        for (int i = 0; i < 3000; i++) begin
            bit rs;
            bit prev_stall;
            rs = ($urandom_range(0, 299) != 0);
            prev_stall = wb_stall;
            if (!(prev_stall && w)) begin
                w  = ($urandom_range(0, 99) < 60);
                wa = 5'($urandom_range(0, 7));
                wd = $urandom;
            end
            if (!hv) begin
                hv = ($urandom_range(0, 99) < 50);
                ha = 5'($urandom_range(0, 7));
                hd = $urandom;
            end
            step(rs, w, wa, wd, hv, ha, hd, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
            if (acc || !rs) hv = 0;
        end

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d left req 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
